calc1_port_checker: RTL and testbench

- Passive per-port checker; one instance per calc1 port.
- Taps the request stream (cmd/data) that the stimulus driver presents to calc1 and the matching calc1 response (resp/data).
- Computes the expected result, tracks the single outstanding request, and flags pass, fail, timeout and protocol errors.
- Synthesisable so it can also run in emulation alongside the DUT.

---
 rtl/calc1_pkg.sv | 25 ++
 rtl/calc1_expect.sv | 27 ++
 rtl/calc1_port_checker.sv | 122 ++++++++++++
 tb/tb_calc1_port_checker.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc1_pkg.sv
// calc1_pkg: shared calc1 command/response encodings and sizes
package calc1_pkg;
    localparam int DATA_W    = 32;
    localparam int NUM_PORTS = 4;

    typedef enum logic [3:0] {
        CMD_NOP = 4'd0,
        CMD_ADD = 4'd1,
        CMD_SUB = 4'd2,
        CMD_LSH = 4'd5,
        CMD_RSH = 4'd6
    } cmd_e;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_OK   = 2'd1,
        RESP_ERR  = 2'd2
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP2,
        ST_WAIT
    } state_e;
endpackage

// File: rtl/calc1_expect.sv
// calc1_expect: combinational reference result for one calc1 request
module calc1_expect
    import calc1_pkg::*;
(
    input  logic [0:3]        cmd,
    input  logic [0:DATA_W-1] op1,
    input  logic [0:DATA_W-1] op2,
    output logic [0:1]        exp_resp,
    output logic [0:DATA_W-1] exp_data
);
    logic [DATA_W:0] sum;
    logic [0:4]      shamt;

    assign sum   = {1'b0, op1} + {1'b0, op2};
    assign shamt = op2[27:31];

    // unknown command codes fall through to ERR with zero data
    always_comb begin
        exp_resp = (cmd == CMD_ADD) ? (sum[DATA_W] ? RESP_ERR : RESP_OK) :
                   (cmd == CMD_SUB) ? ((op1 < op2) ? RESP_ERR : RESP_OK) :
                   (cmd == CMD_LSH || cmd == CMD_RSH) ? RESP_OK : RESP_ERR;
        exp_data = (cmd == CMD_ADD) ? sum[DATA_W-1:0] :
                   (cmd == CMD_SUB) ? op1 - op2 :
                   (cmd == CMD_LSH) ? op1 << shamt :
                   (cmd == CMD_RSH) ? op1 >> shamt : '0;
    end
endmodule

// File: rtl/calc1_port_checker.sv
// calc1_port_checker: passive request/response checker for one calc1 port
module calc1_port_checker
    import calc1_pkg::*;
#(
    parameter int TIMEOUT = 32,
    parameter int CNT_W   = 16
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [0:3]        req_cmd_in,
    input  logic [0:DATA_W-1] req_data_in,
    input  logic [0:1]        out_resp_in,
    input  logic [0:DATA_W-1] out_data_in,
    output logic              busy,
    output logic              chk_pass,
    output logic              chk_fail,
    output logic              chk_timeout,
    output logic              chk_proto_err,
    output logic [0:1]        exp_resp,
    output logic [0:DATA_W-1] exp_data,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count
);
    state_e            state, state_nxt;
    logic [0:3]        cmd_q;
    logic [0:DATA_W-1] op1_q;
    logic [7:0]        tcnt, tcnt_nxt;
    logic [0:1]        e_resp;
    logic [0:DATA_W-1] e_data;
    logic              has_cmd, has_resp, match, at_limit, accept, load_exp;
    logic              pass_nxt, fail_nxt, tmo_nxt, proto_nxt;

    // op2 is only live during OP2, so the expectation is formed straight off the bus
    calc1_expect u_expect (
        .cmd      (cmd_q),
        .op1      (op1_q),
        .op2      (req_data_in),
        .exp_resp (e_resp),
        .exp_data (e_data)
    );

    assign has_cmd  = req_cmd_in != CMD_NOP;
    assign has_resp = out_resp_in != RESP_NONE;
    assign match    = out_resp_in == exp_resp && (exp_resp != RESP_OK || out_data_in == exp_data);
    assign at_limit = tcnt == 8'(TIMEOUT - 1);
    assign busy     = state != ST_IDLE;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = '0;
        accept    = 1'b0;
        load_exp  = 1'b0;
        pass_nxt  = 1'b0;
        fail_nxt  = 1'b0;
        tmo_nxt   = 1'b0;
        proto_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                accept    = has_cmd;
                proto_nxt = has_resp;
                state_nxt = has_cmd ? ST_OP2 : ST_IDLE;
            end
            ST_OP2: begin
                load_exp  = 1'b1;
                proto_nxt = has_cmd | has_resp;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // a response always beats the timeout boundary
                if (has_resp) begin
                    pass_nxt  = match;
                    fail_nxt  = !match;
                    accept    = has_cmd;
                    state_nxt = has_cmd ? ST_OP2 : ST_IDLE;
                end else begin
                    proto_nxt = has_cmd;
                    tmo_nxt   = at_limit;
                    fail_nxt  = at_limit;
                    state_nxt = at_limit ? ST_IDLE : ST_WAIT;
                    tcnt_nxt  = tcnt + 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            tcnt          <= '0;
            cmd_q         <= '0;
            op1_q         <= '0;
            exp_resp      <= '0;
            exp_data      <= '0;
            chk_pass      <= 1'b0;
            chk_fail      <= 1'b0;
            chk_timeout   <= 1'b0;
            chk_proto_err <= 1'b0;
            pass_count    <= '0;
            fail_count    <= '0;
        end else begin
            state         <= state_nxt;
            tcnt          <= tcnt_nxt;
            chk_pass      <= pass_nxt;
            chk_fail      <= fail_nxt;
            chk_timeout   <= tmo_nxt;
            chk_proto_err <= proto_nxt;
            if (accept) begin
                cmd_q <= req_cmd_in;
                op1_q <= req_data_in;
            end
            if (load_exp) begin
                exp_resp <= e_resp;
                exp_data <= e_data;
            end
            if (pass_nxt && pass_count != '1)
                pass_count <= pass_count + CNT_W'(1);
            if (fail_nxt && fail_count != '1)
                fail_count <= fail_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_calc1_port_checker.sv
// tb_calc1_port_checker: scoreboard bench for calc1_port_checker
module tb_calc1_port_checker;
    localparam int TMO = 32;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          c_clk = 1'b0;
    logic          reset = 1'b1;
    logic [0:3]    req_cmd_in = '0;
    logic [0:31]   req_data_in = '0;
    logic [0:1]    out_resp_in = '0;
    logic [0:31]   out_data_in = '0;
    logic          busy, chk_pass, chk_fail, chk_timeout, chk_proto_err;
    logic [0:1]    exp_resp;
    logic [0:31]   exp_data;
    logic [CW-1:0] pass_count, fail_count;

    calc1_port_checker #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
        .c_clk         (c_clk),
        .reset         (reset),
        .req_cmd_in    (req_cmd_in),
        .req_data_in   (req_data_in),
        .out_resp_in   (out_resp_in),
        .out_data_in   (out_data_in),
        .busy          (busy),
        .chk_pass      (chk_pass),
        .chk_fail      (chk_fail),
        .chk_timeout   (chk_timeout),
        .chk_proto_err (chk_proto_err),
        .exp_resp      (exp_resp),
        .exp_data      (exp_data),
        .pass_count    (pass_count),
        .fail_count    (fail_count)
    );

    always #5 c_clk = ~c_clk;

    // pulse vector order: pass, fail, timeout, proto
    localparam logic [3:0] P_PASS = 4'b1000, P_FAIL = 4'b0100, P_TMO = 4'b0110, P_PROTO = 4'b0001, P_NONE = 4'b0000;

    logic [3:0] pulses, obs, stray, e;
    logic [3:0] sb[$];
    logic [1:0] m_resp;
    logic [31:0] m_data;
    int n_chk = 0, n_pass = 0, m_pass = 0, m_fail = 0;

    assign pulses = {chk_pass, chk_fail, chk_timeout, chk_proto_err};

    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [1:0] r, output logic [31:0] d);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        r = 2'd2;
        d = '0;
        if (c == 4'd1) begin r = s[32] ? 2'd2 : 2'd1; d = s[31:0]; end
        else if (c == 4'd2) begin r = (a < b) ? 2'd2 : 2'd1; d = a - b; end
        else if (c == 4'd5) begin r = 2'd1; d = a << b[4:0]; end
        else if (c == 4'd6) begin r = 2'd1; d = a >> b[4:0]; end
    endfunction

    task automatic cyc(input logic [3:0] c, input logic [31:0] d, input logic [1:0] r, input logic [31:0] rd);
        req_cmd_in = c; req_data_in = d; out_resp_in = r; out_data_in = rd;
        @(posedge c_clk); #1;
        obs = pulses;
        req_cmd_in = '0; req_data_in = '0; out_resp_in = '0; out_data_in = '0;
    endtask

    task automatic push_result(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                               input logic [1:0] r, input logic [31:0] rd);
        model(c, a, b, m_resp, m_data);
        if (r == m_resp && (m_resp != 2'd1 || rd == m_data)) begin
            sb.push_back(P_PASS);
            m_pass = (m_pass == CMAX) ? CMAX : m_pass + 1;
        end else begin
            sb.push_back(P_FAIL);
            m_fail = (m_fail == CMAX) ? CMAX : m_fail + 1;
        end
    endtask

    task automatic do_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int lat,
                          input logic [1:0] r, input logic [31:0] rd);
        stray = '0;
        cyc(c, a, 2'd0, 0); stray |= obs;
        cyc(4'd0, b, 2'd0, 0); stray |= obs;
        repeat (lat) begin cyc(4'd0, 0, 2'd0, 0); stray |= obs; end
        push_result(c, a, b, r, rd);
        cyc(4'd0, 0, r, rd);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge c_clk);
        #1;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (pulses !== P_NONE) $display("FAIL reset_pulses got %b want %b", pulses, P_NONE); else n_pass++;
        n_chk++; if ({exp_resp, exp_data} !== 34'd0) $display("FAIL reset_exp got %h/%h want 0/0", exp_resp, exp_data); else n_pass++;
        n_chk++; if ({pass_count, fail_count} !== '0) $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, fail_count); else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_add;
        do_req(4'd1, 32'hFFFF0000, 32'h0000FFFF, 3, 2'd1, 32'hFFFFFFFF);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL add_ok_pulse got %b want %b", obs, e); else n_pass++;
        n_chk++; if (stray !== P_NONE) $display("FAIL add_ok_early_pulse got %b want 0000", stray); else n_pass++;
        n_chk++; if (exp_resp !== 2'd1 || exp_data !== 32'hFFFFFFFF) $display("FAIL add_ok_exp got %h/%h want 1/ffffffff", exp_resp, exp_data); else n_pass++;
        n_chk++; if (pass_count !== CW'(m_pass)) $display("FAIL add_ok_pass_count got %0d want %0d", pass_count, m_pass); else n_pass++;
        do_req(4'd1, 32'hFFFFFFFF, 32'h00000001, 1, 2'd1, 32'h00000000);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL add_ovf_pulse got %b want %b", obs, e); else n_pass++;
        n_chk++; if (exp_resp !== 2'd2) $display("FAIL add_ovf_exp_resp got %0d want 2", exp_resp); else n_pass++;
        n_chk++; if (fail_count !== CW'(m_fail)) $display("FAIL add_ovf_fail_count got %0d want %0d", fail_count, m_fail); else n_pass++;
    endtask

    task automatic test_sub_shift;
        logic [3:0]  cs[4] = '{4'd2, 4'd5, 4'd6, 4'd9};
        logic [31:0] as[4] = '{32'h00000001, 32'h00000001, 32'h80000000, 32'h12345678};
        logic [31:0] bs[4] = '{32'h80000000, 32'h00000024, 32'h0000003F, 32'h1};
        logic [1:0]  rs[4] = '{2'd2, 2'd1, 2'd1, 2'd2};
        logic [31:0] ds[4] = '{32'h0, 32'h00000010, 32'h00000001, 32'h0};
        for (int i = 0; i < 4; i++) begin
            do_req(cs[i], as[i], bs[i], i, rs[i], ds[i]);
            e = sb.pop_front();
            n_chk++; if (obs !== e) $display("FAIL sub_shift_%0d_pulse got %b want %b", i, obs, e); else n_pass++;
        end
        n_chk++; if (pass_count !== CW'(m_pass)) $display("FAIL sub_shift_pass_count got %0d want %0d", pass_count, m_pass); else n_pass++;
    endtask

    task automatic test_timeout;
        stray = '0;
        cyc(4'd1, 5, 2'd0, 0);
        cyc(4'd0, 7, 2'd0, 0);
        repeat (TMO - 1) begin cyc(4'd0, 0, 2'd0, 0); stray |= obs; end
        n_chk++; if (stray !== P_NONE || busy !== 1'b1) $display("FAIL tmo_early got %b busy %b want 0000 busy 1", stray, busy); else n_pass++;
        sb.push_back(P_TMO);
        m_fail = (m_fail == CMAX) ? CMAX : m_fail + 1;
        cyc(4'd0, 0, 2'd0, 0);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL tmo_pulse got %b want %b", obs, e); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL tmo_busy got %b want 0", busy); else n_pass++;
        n_chk++; if (fail_count !== CW'(m_fail)) $display("FAIL tmo_fail_count got %0d want %0d", fail_count, m_fail); else n_pass++;
        do_req(4'd1, 5, 7, TMO - 1, 2'd1, 12);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL tmo_edge_resp_pulse got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_proto;
        sb.push_back(P_PROTO);
        cyc(4'd0, 0, 2'd1, 5);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL proto_idle_pulse got %b want %b", obs, e); else n_pass++;
        n_chk++; if (pass_count !== CW'(m_pass) || fail_count !== CW'(m_fail)) $display("FAIL proto_idle_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, m_pass, m_fail); else n_pass++;
        cyc(4'd2, 9, 2'd0, 0);
        cyc(4'd0, 4, 2'd0, 0);
        sb.push_back(P_PROTO);
        cyc(4'd1, 32'hAB, 2'd0, 0);
        e = sb.pop_front();
        n_chk++; if (obs !== e || busy !== 1'b1) $display("FAIL proto_wait_pulse got %b busy %b want %b busy 1", obs, busy, e); else n_pass++;
        push_result(4'd2, 9, 4, 2'd1, 5);
        cyc(4'd0, 0, 2'd1, 5);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL proto_wait_then_resp got %b want %b", obs, e); else n_pass++;
        cyc(4'd1, 3, 2'd0, 0);
        sb.push_back(P_PROTO);
        cyc(4'd2, 4, 2'd0, 0);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL proto_op2_pulse got %b want %b", obs, e); else n_pass++;
        push_result(4'd1, 3, 4, 2'd1, 7);
        cyc(4'd0, 0, 2'd1, 7);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL proto_op2_then_resp got %b want %b", obs, e); else n_pass++;
        n_chk++; if (pass_count !== CW'(m_pass) || fail_count !== CW'(m_fail)) $display("FAIL proto_counts got %0d/%0d want %0d/%0d", pass_count, fail_count, m_pass, m_fail); else n_pass++;
    endtask

    task automatic test_back_to_back;
        cyc(4'd1, 1, 2'd0, 0);
        cyc(4'd0, 2, 2'd0, 0);
        push_result(4'd1, 1, 2, 2'd1, 3);
        cyc(4'd2, 10, 2'd1, 3);
        e = sb.pop_front();
        n_chk++; if (obs !== e || busy !== 1'b1) $display("FAIL b2b_first got %b busy %b want %b busy 1", obs, busy, e); else n_pass++;
        cyc(4'd0, 3, 2'd0, 0);
        n_chk++; if (obs !== P_NONE || exp_resp !== 2'd1 || exp_data !== 32'd7) $display("FAIL b2b_second_exp got %b %h/%h want 0000 1/00000007", obs, exp_resp, exp_data); else n_pass++;
        push_result(4'd2, 10, 3, 2'd1, 7);
        cyc(4'd0, 0, 2'd1, 7);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL b2b_second got %b want %b", obs, e); else n_pass++;
    endtask

    task automatic test_reset_mid;
        cyc(4'd1, 1, 2'd0, 0);
        cyc(4'd0, 1, 2'd0, 0);
        cyc(4'd0, 0, 2'd0, 0);
        reset = 1'b1;
        #2;
        n_chk++; if (busy !== 1'b0 || pass_count !== '0 || fail_count !== '0) $display("FAIL rst_mid_state got busy %b %0d/%0d want busy 0 0/0", busy, pass_count, fail_count); else n_pass++;
        @(posedge c_clk); #1;
        n_chk++; if (pulses !== P_NONE) $display("FAIL rst_mid_pulses got %b want 0000", pulses); else n_pass++;
        reset = 1'b0;
        m_pass = 0; m_fail = 0;
        do_req(4'd1, 32'h55555555, 32'hAAAAAAAA, 2, 2'd1, 32'hFFFFFFFF);
        e = sb.pop_front();
        n_chk++; if (obs !== e) $display("FAIL rst_mid_next_pulse got %b want %b", obs, e); else n_pass++;
        n_chk++; if (pass_count !== CW'(m_pass)) $display("FAIL rst_mid_pass_count got %0d want %0d", pass_count, m_pass); else n_pass++;
    endtask

    task automatic test_saturate;
        for (int i = 0; i < CMAX + 1; i++) begin
            do_req(4'd1, i, 1, 0, 2'd1, i + 1);
            e = sb.pop_front();
            n_chk++; if (obs !== e) $display("FAIL sat_%0d_pulse got %b want %b", i, obs, e); else n_pass++;
        end
        n_chk++; if (pass_count !== CW'(m_pass) || m_pass != CMAX) $display("FAIL sat_pass_count got %0d want %0d", pass_count, CMAX); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub_shift;
        test_timeout;
        test_proto;
        test_back_to_back;
        test_reset_mid;
        test_saturate;
        n_chk++; if (sb.size() != 0) $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
